divider_core: RTL and testbench

DIVIDER_CORE -- requirements
Module: divider_core

---
 rtl/divider_pkg.sv | 23 ++
 rtl/divider_step.sv | 24 ++
 rtl/divider_core.sv | 144 ++++++++++++++
 tb/tb_divider_core.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and constants for the 32-bit restoring divider.
package divider_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_LATENCY = 34;
  localparam int CNT_W       = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] remainder;
  } result_t;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v);
    return v[DIV_WIDTH-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring shift-subtract iteration: shift next dividend bit into the partial remainder,
// subtract the divisor when it fits, and shift the resulting quotient bit in. Purely combinational.
module divider_step
  import divider_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic [DIV_WIDTH-1:0] quo_i,
  input  logic [DIV_WIDTH-1:0] dvs_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic [DIV_WIDTH-1:0] quo_o
);

  logic [DIV_WIDTH:0] shifted;
  logic               q_bit;

  always_comb begin
    shifted = {rem_i, quo_i[DIV_WIDTH-1]};
    q_bit   = (shifted >= {1'b0, dvs_i});
    // A successful subtract always leaves a value below the divisor, so 32 bits suffice.
    rem_o   = q_bit ? (shifted[DIV_WIDTH-1:0] - dvs_i) : shifted[DIV_WIDTH-1:0];
    quo_o   = {quo_i[DIV_WIDTH-2:0], q_bit};
  end

endmodule

// File: rtl/divider_core.sv
// 32/32 iterative restoring divider; DIVIDER_CORE_SIGNED_EN selects two's-complement operands.
// Latency: accept at edge N -> one-cycle result strobe after edge N+34; next accept at N+35.
// No backpressure: operands offered while busy, or with only one tvalid, are dropped.
module divider_core
  import divider_pkg::*;
(
  input  logic                   aclk,
  input  logic                   rst,
  input  logic                   s_axis_divisor_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_divisor_tdata,
  input  logic                   s_axis_dividend_tvalid,
  input  logic [DIV_WIDTH-1:0]   s_axis_dividend_tdata,
  output logic                   m_axis_dout_tvalid,
  output logic [2*DIV_WIDTH-1:0] m_axis_dout_tdata
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] rem_q, rem_d;
  logic [DIV_WIDTH-1:0] quo_q, quo_d;
  logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
  result_t              corr_q, corr_d;
  logic                 corr_vld_q, corr_vld_d;
  result_t              dout_q, dout_d;
  logic                 vld_q, vld_d;
  result_t              corr;
  logic [DIV_WIDTH-1:0] rem_nxt, quo_nxt;
`ifdef DIVIDER_CORE_SIGNED_EN
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 div0_q, div0_d;
`endif

  divider_step u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nxt),
    .quo_o (quo_nxt)
  );

  // Sign fix-up; a zero divisor keeps the all-ones quotient regardless of operand signs.
  always_comb begin
    corr.quotient  = quo_q;
    corr.remainder = rem_q;
`ifdef DIVIDER_CORE_SIGNED_EN
    if (neg_quo_q && !div0_q) corr.quotient = ~quo_q + 1'b1;
    if (neg_rem_q)            corr.remainder = ~rem_q + 1'b1;
`endif
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    corr_d     = corr_q;
    corr_vld_d = corr_vld_q;
    dout_d     = dout_q;
    vld_d      = 1'b0;
`ifdef DIVIDER_CORE_SIGNED_EN
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div0_d     = div0_q;
`endif
    case (state_q)
      IDLE: begin
        if (s_axis_divisor_tvalid && s_axis_dividend_tvalid) begin
          state_d = CALC;
          cnt_d   = CNT_W'(DIV_WIDTH-1);
          rem_d   = '0;
`ifdef DIVIDER_CORE_SIGNED_EN
          quo_d     = abs_val(s_axis_dividend_tdata);
          dvs_d     = abs_val(s_axis_divisor_tdata);
          neg_rem_d = s_axis_dividend_tdata[DIV_WIDTH-1];
          neg_quo_d = s_axis_dividend_tdata[DIV_WIDTH-1] ^ s_axis_divisor_tdata[DIV_WIDTH-1];
          div0_d    = (s_axis_divisor_tdata == '0);
`else
          quo_d     = s_axis_dividend_tdata;
          dvs_d     = s_axis_divisor_tdata;
`endif
        end
      end
      CALC: begin
        rem_d = rem_nxt;
        quo_d = quo_nxt;
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DONE: begin
        // First DONE cycle registers the corrected result, second publishes it.
        if (corr_vld_q) begin
          dout_d     = corr_q;
          vld_d      = 1'b1;
          corr_vld_d = 1'b0;
          state_d    = IDLE;
        end else begin
          corr_d     = corr;
          corr_vld_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      corr_q     <= '0;
      corr_vld_q <= 1'b0;
      dout_q     <= '0;
      vld_q      <= 1'b0;
`ifdef DIVIDER_CORE_SIGNED_EN
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div0_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      corr_q     <= corr_d;
      corr_vld_q <= corr_vld_d;
      dout_q     <= dout_d;
      vld_q      <= vld_d;
`ifdef DIVIDER_CORE_SIGNED_EN
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div0_q     <= div0_d;
`endif
    end
  end

  assign m_axis_dout_tvalid = vld_q;
  assign m_axis_dout_tdata  = dout_q;

endmodule

// File: tb/tb_divider_core.sv
// Directed scoreboard bench for divider_core; expectations follow DIVIDER_CORE_SIGNED_EN.
module tb_divider_core;

  logic        aclk = 1'b0;
  logic        rst;
  logic        s_axis_divisor_tvalid;
  logic [31:0] s_axis_divisor_tdata;
  logic        s_axis_dividend_tvalid;
  logic [31:0] s_axis_dividend_tdata;
  logic        m_axis_dout_tvalid;
  logic [63:0] m_axis_dout_tdata;

  divider_core dut (
    .aclk                   (aclk),
    .rst                    (rst),
    .s_axis_divisor_tvalid  (s_axis_divisor_tvalid),
    .s_axis_divisor_tdata   (s_axis_divisor_tdata),
    .s_axis_dividend_tvalid (s_axis_dividend_tvalid),
    .s_axis_dividend_tdata  (s_axis_dividend_tdata),
    .m_axis_dout_tvalid     (m_axis_dout_tvalid),
    .m_axis_dout_tdata      (m_axis_dout_tdata)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int          edge_n;
    logic [63:0] dat;
    int          id;
  } exp_t;

  exp_t exp_q[$];
  int errors  = 0;
  int checks  = 0;
  int strobes = 0;

  // Monitor: every strobe must match the oldest outstanding expectation, 34 edges after acceptance.
  always @(negedge aclk) begin
    exp_t e;
    if (m_axis_dout_tvalid === 1'b1) begin
      strobes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: edge %0d tdata=%h, required no strobe", cyc, m_axis_dout_tdata);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (m_axis_dout_tdata !== e.dat) begin
          errors++;
          $display("FAIL data_op%0d: got %h expected %h", e.id, m_axis_dout_tdata, e.dat);
        end
        checks++;
        if (cyc != e.edge_n + 34) begin
          errors++;
          $display("FAIL latency_op%0d: strobe after edge %0d expected after edge %0d", e.id, cyc, e.edge_n + 34);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one cycle of operands from a negedge; acceptance (if any) happens at edge cyc+1.
  task automatic send(input logic vdd, input logic vdv, input logic [31:0] dd, input logic [31:0] dv,
                      input bit expect_it, input logic [63:0] exp_dat, input int id);
    exp_t e;
    s_axis_dividend_tvalid = vdd;
    s_axis_dividend_tdata  = dd;
    s_axis_divisor_tvalid  = vdv;
    s_axis_divisor_tdata   = dv;
    if (expect_it) begin
      e = '{edge_n: cyc + 1, dat: exp_dat, id: id};
      exp_q.push_back(e);
    end
    @(negedge aclk);
    s_axis_dividend_tvalid = 1'b0;
    s_axis_divisor_tvalid  = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      tick(1);
      b++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles, expected 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int n;
    int s0;
    rst = 1'b1;
    s_axis_dividend_tvalid = 1'b0;
    s_axis_divisor_tvalid  = 1'b0;
    s_axis_dividend_tdata  = '0;
    s_axis_divisor_tdata   = '0;
    tick(3);
    chk("reset_tvalid", {63'd0, m_axis_dout_tvalid}, 64'd0);
    chk("reset_tdata", m_axis_dout_tdata, 64'd0);
    rst = 1'b0;
    tick(1);

    // Basic unsigned-safe case, single-cycle strobe and output hold.
    send(1, 1, 32'd100, 32'd7, 1, {32'd14, 32'd2}, 1);
    drain(60);
    tick(1);
    chk("strobe_one_cycle", {63'd0, m_axis_dout_tvalid}, 64'd0);
    tick(5);
    chk("tdata_hold", m_axis_dout_tdata, {32'd14, 32'd2});

`ifdef DIVIDER_CORE_SIGNED_EN
    send(1, 1, 32'hFFFFFFF9, 32'd2, 1, {32'hFFFFFFFD, 32'hFFFFFFFF}, 2);
    drain(60);
    send(1, 1, 32'd7, 32'hFFFFFFFE, 1, {32'hFFFFFFFD, 32'd1}, 3);
    drain(60);
    send(1, 1, 32'h80000000, 32'hFFFFFFFF, 1, {32'h80000000, 32'd0}, 5);
    drain(60);
`else
    send(1, 1, 32'hFFFFFFF9, 32'd2, 1, {32'h7FFFFFFC, 32'd1}, 2);
    drain(60);
    send(1, 1, 32'd7, 32'hFFFFFFFE, 1, {32'd0, 32'd7}, 3);
    drain(60);
    send(1, 1, 32'h80000000, 32'hFFFFFFFF, 1, {32'd0, 32'h80000000}, 5);
    drain(60);
`endif
    // Divide by zero: all-ones quotient, remainder is the dividend as given.
    send(1, 1, 32'd5, 32'd0, 1, {32'hFFFFFFFF, 32'd5}, 4);
    drain(60);
    send(1, 1, 32'hFFFFFFF9, 32'd0, 1, {32'hFFFFFFFF, 32'hFFFFFFF9}, 6);
    drain(60);

    // Busy drop at N+10 and lone-tvalid pulses in IDLE: exactly one strobe.
    s0 = strobes;
    send(1, 1, 32'd1000, 32'd3, 1, {32'd333, 32'd1}, 7);
    tick(9);
    send(1, 1, 32'd50, 32'd5, 0, 64'd0, 0);
    drain(60);
    send(1, 0, 32'd9, 32'd3, 0, 64'd0, 0);
    tick(2);
    send(0, 1, 32'd9, 32'd3, 0, 64'd0, 0);
    tick(45);
    chk("busy_and_single_strobes", 64'(strobes - s0), 64'd1);

    // Back-to-back: pair at N+34 (DONE) ignored, pair at N+35 accepted.
    n = cyc + 1;
    send(1, 1, 32'd1000001, 32'd1000, 1, {32'd1000, 32'd1}, 8);
    while (cyc < n + 33) tick(1);
    send(1, 1, 32'd9, 32'd9, 0, 64'd0, 0);
    send(1, 1, 32'd20, 32'd6, 1, {32'd3, 32'd2}, 9);
    drain(80);

    // Reset at N+20 aborts; operands presented during reset are ignored; new pair at N+22.
    n = cyc + 1;
    send(1, 1, 32'd100, 32'd7, 1, {32'd14, 32'd2}, 10);
    while (cyc < n + 19) tick(1);
    rst = 1'b1;
    s_axis_dividend_tvalid = 1'b1;
    s_axis_divisor_tvalid  = 1'b1;
    s_axis_dividend_tdata  = 32'd1;
    s_axis_divisor_tdata   = 32'd1;
    exp_q.delete();
    tick(1);
    rst = 1'b0;
    s_axis_dividend_tvalid = 1'b0;
    s_axis_divisor_tvalid  = 1'b0;
    chk("midcalc_reset_tvalid", {63'd0, m_axis_dout_tvalid}, 64'd0);
    chk("midcalc_reset_tdata", m_axis_dout_tdata, 64'd0);
    tick(1);
    send(1, 1, 32'd77, 32'd10, 1, {32'd7, 32'd7}, 11);
    drain(60);
    tick(3);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
